cv32e40p_tb_run_monitor: RTL and testbench

Synthesizable run controller for the cv32e40p bench. It generalises the ad-hoc testbench reset, cycle-count, max-cycle and exit logic to NUM_CHANNELS cores or harts.
- Sequences the core reset after the global reset.
- Counts test application time.
- Aggregates per-channel pass/fail/exit reports into one sticky verdict, with an optional hang watchdog.
- Instantiated by the bench top between clock/reset generation and the tb subsystem(s); the top only observes done_o and status_o and calls $finish.

---
 rtl/cv32e40p_tb_run_monitor_pkg.sv | 25 ++
 rtl/cv32e40p_tb_hang_wdog.sv | 44 ++++
 rtl/cv32e40p_tb_run_monitor.sv | 189 ++++++++++++++++++
 tb/tb_cv32e40p_tb_run_monitor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_tb_run_monitor_pkg.sv
// Shared types and constants for the cv32e40p bench run monitor.
package cv32e40p_tb_pkg;

    localparam int unsigned EXIT_VALUE_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_NONE    = 3'd0,
        ST_PASS    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_HANG    = 3'd4
    } run_status_e;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_e;

    // A reported exit code counts as a failure when it is nonzero.
    function automatic logic exit_is_fail(input logic [EXIT_VALUE_WIDTH-1:0] code);
        return |code;
    endfunction

endpackage

// File: rtl/cv32e40p_tb_hang_wdog.sv
// Per-channel retirement watchdog; compiled only with
// CV32E40P_TB_RUN_MONITOR_HANG_WATCHDOG_EN defined.
`ifdef CV32E40P_TB_RUN_MONITOR_HANG_WATCHDOG_EN
module cv32e40p_tb_hang_wdog #(
    parameter int unsigned HANG_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic retired_i,
    output logic hung_o
);

    localparam int unsigned CW = $clog2(HANG_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(HANG_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count idle cycles of an active channel; any retirement restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || retired_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // The idle cycle that would bring the count to HANG_CYCLES flags the hang.
    assign hung_o = en_i && !retired_i && (cnt_q == LAST);

    // Idle counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/cv32e40p_tb_run_monitor.sv
// Bench run controller: core reset sequencing, run-time counting and verdict
// aggregation. Optional hang watchdog: CV32E40P_TB_RUN_MONITOR_HANG_WATCHDOG_EN.
module cv32e40p_tb_run_monitor
    import cv32e40p_tb_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS      = 1,
    parameter int unsigned CNT_WIDTH         = 32,
    parameter int unsigned RESET_WAIT_CYCLES = 4,
    parameter int unsigned HANG_CYCLES       = 1024
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [CNT_WIDTH-1:0]                     maxcycles_i,
    input  logic                                     fail_fast_i,
    input  logic [NUM_CHANNELS-1:0]                  passed_i,
    input  logic [NUM_CHANNELS-1:0]                  failed_i,
    input  logic [NUM_CHANNELS-1:0]                  exit_valid_i,
    input  logic [NUM_CHANNELS*EXIT_VALUE_WIDTH-1:0] exit_value_i,
    input  logic [NUM_CHANNELS-1:0]                  retired_i,
    output logic                                     core_rst_no,
    output logic                                     done_o,
    output logic [2:0]                               status_o,
    output logic [CNT_WIDTH-1:0]                     tat_cycles_o,
    output logic [NUM_CHANNELS-1:0]                  finished_o,
    output logic [NUM_CHANNELS-1:0]                  fail_mask_o,
    output logic [4:0]                               fail_chan_o,
    output logic [EXIT_VALUE_WIDTH-1:0]              fail_value_o
);

    localparam int unsigned HOLD_W = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_WAIT_CYCLES - 1);

    run_state_e                  state_q, state_d;
    run_status_e                 status_q, status_d;
    logic [HOLD_W-1:0]           hold_q, hold_d;
    logic                        core_rst_q, core_rst_d;
    logic                        done_q, done_d;
    logic [CNT_WIDTH-1:0]        tat_q, tat_d;
    logic [NUM_CHANNELS-1:0]     fin_q, fin_d, fmask_q, fmask_d;
    logic [4:0]                  fchan_q, fchan_d;
    logic [EXIT_VALUE_WIDTH-1:0] fval_q, fval_d;

    logic [NUM_CHANNELS-1:0]     new_ev_s, new_fail_s, fail_now_s, hung_s;
    logic [4:0]                  first_chan_s, hung_chan_s;
    logic [EXIT_VALUE_WIDTH-1:0] first_val_s;
    logic [CNT_WIDTH:0]          tat_inc_s;
    logic                        timeout_s;

`ifdef CV32E40P_TB_RUN_MONITOR_HANG_WATCHDOG_EN
    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_wdog
        cv32e40p_tb_hang_wdog #(
            .HANG_CYCLES (HANG_CYCLES)
        ) u_wdog (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .en_i      ((state_q == RUN) && !fin_q[k]),
            .retired_i (retired_i[k]),
            .hung_o    (hung_s[k])
        );
    end
`else
    logic unused_s;
    assign hung_s   = '0;
    assign unused_s = ^retired_i ^ (HANG_CYCLES == 32'd0);
`endif

    assign new_ev_s   = (state_q == RUN) ? ((passed_i | failed_i | exit_valid_i) & ~fin_q) : '0;
    assign new_fail_s = new_ev_s & fail_now_s;
    assign tat_inc_s  = {1'b0, tat_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign timeout_s  = (maxcycles_i != '0) && (tat_inc_s >= {1'b0, maxcycles_i});

    // Per-channel failure decode; descending scan leaves the lowest index selected.
    always_comb begin
        fail_now_s   = '0;
        first_chan_s = 5'd0;
        first_val_s  = '0;
        hung_chan_s  = 5'd0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            fail_now_s[k] = failed_i[k] | (exit_valid_i[k] &
                exit_is_fail(exit_value_i[k*EXIT_VALUE_WIDTH +: EXIT_VALUE_WIDTH]));
            first_chan_s  = (new_ev_s[k] && fail_now_s[k]) ? 5'(k) : first_chan_s;
            first_val_s   = (new_ev_s[k] && fail_now_s[k]) ?
                            (failed_i[k] ? '0 : exit_value_i[k*EXIT_VALUE_WIDTH +: EXIT_VALUE_WIDTH]) :
                            first_val_s;
            hung_chan_s   = hung_s[k] ? 5'(k) : hung_chan_s;
        end
    end

    // Next-state logic for the HOLD -> RUN -> DONE sequence and verdict capture.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        hold_d     = hold_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        tat_d      = tat_q;
        fin_d      = fin_q;
        fmask_d    = fmask_q;
        fchan_d    = fchan_q;
        fval_d     = fval_q;
        case (state_q)
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d    = RUN;
                    core_rst_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RUN: begin
                tat_d   = (&tat_q) ? tat_q : tat_inc_s[CNT_WIDTH-1:0];
                fin_d   = fin_q | new_ev_s;
                fmask_d = fmask_q | new_fail_s;
                if ((fmask_q == '0) && (new_fail_s != '0)) begin
                    fchan_d = first_chan_s;
                    fval_d  = first_val_s;
                end else begin
                    fchan_d = fchan_q;
                    fval_d  = fval_q;
                end
                // Termination uses the flags updated with this cycle's events.
                if ((fmask_d != '0) && (fail_fast_i || (&fin_d))) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    status_d = ST_FAIL;
                end else if (&fin_d) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    status_d = ST_PASS;
                end else if (hung_s != '0) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    status_d = ST_HANG;
                    fchan_d  = hung_chan_s;
                    fval_d   = '0;
                end else if (timeout_s) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    status_d = ST_TIMEOUT;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    // State and verdict registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= HOLD;
            status_q   <= ST_NONE;
            hold_q     <= '0;
            core_rst_q <= 1'b0;
            done_q     <= 1'b0;
            tat_q      <= '0;
            fin_q      <= '0;
            fmask_q    <= '0;
            fchan_q    <= 5'd0;
            fval_q     <= '0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            hold_q     <= hold_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            tat_q      <= tat_d;
            fin_q      <= fin_d;
            fmask_q    <= fmask_d;
            fchan_q    <= fchan_d;
            fval_q     <= fval_d;
        end
    end

    assign core_rst_no  = core_rst_q;
    assign done_o       = done_q;
    assign status_o     = status_q;
    assign tat_cycles_o = tat_q;
    assign finished_o   = fin_q;
    assign fail_mask_o  = fmask_q;
    assign fail_chan_o  = fchan_q;
    assign fail_value_o = fval_q;

endmodule

// File: tb/tb_cv32e40p_tb_run_monitor.sv
// Self-checking bench for cv32e40p_tb_run_monitor: directed scenarios plus
// randomized event schedules scored against a per-cycle behavioural model.
module tb_cv32e40p_tb_run_monitor;
    import cv32e40p_tb_pkg::*;

    localparam int NCH  = 4;
    localparam int MAXC = 300;
    localparam int HANG = 16;

    logic              clk, rst_n, fail_fast;
    logic [31:0]       maxcycles;
    logic [NCH-1:0]    passed, failed, exit_valid, retired;
    logic [NCH*32-1:0] exit_value;
    logic              core_rst_n, done;
    logic [2:0]        status;
    logic [31:0]       tat, fail_value;
    logic [NCH-1:0]    finished, fail_mask;
    logic [4:0]        fail_chan;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus schedule indexed by RUN cycle.
    logic [NCH-1:0] s_pass [MAXC];
    logic [NCH-1:0] s_fail [MAXC];
    logic [NCH-1:0] s_exit [MAXC];
    logic [NCH-1:0] s_ret  [MAXC];
    logic [31:0]    s_code [MAXC][NCH];

    // Reference model state.
    logic [NCH-1:0] m_fin, m_fmask;
    logic           m_done;
    logic [2:0]     m_status;
    logic [31:0]    m_tat, m_val;
    logic [4:0]     m_chan;
`ifdef CV32E40P_TB_RUN_MONITOR_HANG_WATCHDOG_EN
    int m_idle [NCH];
`endif

    cv32e40p_tb_run_monitor #(
        .NUM_CHANNELS      (NCH),
        .CNT_WIDTH         (32),
        .RESET_WAIT_CYCLES (4),
        .HANG_CYCLES       (HANG)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .maxcycles_i  (maxcycles),
        .fail_fast_i  (fail_fast),
        .passed_i     (passed),
        .failed_i     (failed),
        .exit_valid_i (exit_valid),
        .exit_value_i (exit_value),
        .retired_i    (retired),
        .core_rst_no  (core_rst_n),
        .done_o       (done),
        .status_o     (status),
        .tat_cycles_o (tat),
        .finished_o   (finished),
        .fail_mask_o  (fail_mask),
        .fail_chan_o  (fail_chan),
        .fail_value_o (fail_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        passed = '0; failed = '0; exit_valid = '0; exit_value = '0; retired = '0;
    endtask

    task automatic clear_sched();
        for (int c = 0; c < MAXC; c++) begin
            s_pass[c] = '0; s_fail[c] = '0; s_exit[c] = '0; s_ret[c] = '1;
            for (int k = 0; k < NCH; k++) s_code[c][k] = 32'd0;
        end
    endtask

    task automatic apply_inputs(input int c);
        passed = s_pass[c]; failed = s_fail[c]; exit_valid = s_exit[c]; retired = s_ret[c];
        for (int k = 0; k < NCH; k++) exit_value[k*32 +: 32] = s_code[c][k];
    endtask

    task automatic check_reset_vals();
        check_eq("rst_core_rst", {31'd0, core_rst_n}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_status", {29'd0, status}, 32'd0);
        check_eq("rst_tat", tat, 32'd0);
        check_eq("rst_finished", {28'd0, finished}, 32'd0);
        check_eq("rst_fail_mask", {28'd0, fail_mask}, 32'd0);
        check_eq("rst_fail_chan", {27'd0, fail_chan}, 32'd0);
        check_eq("rst_fail_value", fail_value, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        check_reset_vals();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check_eq("seq_core_rst", {31'd0, core_rst_n}, (i == 4) ? 32'd1 : 32'd0);
        end
        check_eq("run_entry_tat", tat, 32'd0);
        m_fin = '0; m_fmask = '0; m_done = 1'b0; m_status = 3'd0;
        m_tat = 32'd0; m_val = 32'd0; m_chan = 5'd0;
`ifdef CV32E40P_TB_RUN_MONITOR_HANG_WATCHDOG_EN
        for (int k = 0; k < NCH; k++) m_idle[k] = 0;
`endif
    endtask

    // One RUN cycle of the reference: apply the reporting rules, then decide termination.
    task automatic model_step(input int c, input logic [31:0] maxc, input logic ff);
        logic           have_before, cap, timeout;
        logic [NCH-1:0] hung;
        logic [31:0]    code;
        if (m_done) return;
        have_before = (m_fmask != '0);
        cap = 1'b0;
        hung = '0;
`ifdef CV32E40P_TB_RUN_MONITOR_HANG_WATCHDOG_EN
        for (int k = 0; k < NCH; k++) begin
            if (m_fin[k] || s_ret[c][k]) m_idle[k] = 0;
            else begin
                m_idle[k]++;
                if (m_idle[k] >= HANG) hung[k] = 1'b1;
            end
        end
`endif
        for (int k = 0; k < NCH; k++) begin
            code = s_code[c][k];
            if (!m_fin[k] && (s_pass[c][k] || s_fail[c][k] || s_exit[c][k])) begin
                m_fin[k] = 1'b1;
                if (s_fail[c][k] || (s_exit[c][k] && code != 32'd0)) begin
                    m_fmask[k] = 1'b1;
                    if (!have_before && !cap) begin
                        cap = 1'b1;
                        m_chan = 5'(k);
                        m_val = s_fail[c][k] ? 32'd0 : code;
                    end
                end
            end
        end
        timeout = (maxc != 32'd0) && ((64'(m_tat) + 64'd1) >= 64'(maxc));
        if (m_tat != 32'hFFFF_FFFF) m_tat = m_tat + 32'd1;
        if (m_fmask != '0 && (ff || m_fin == '1)) begin
            m_done = 1'b1; m_status = 3'd2;
        end else if (m_fin == '1) begin
            m_done = 1'b1; m_status = 3'd1;
        end else if (hung != '0) begin
            m_done = 1'b1; m_status = 3'd4; m_val = 32'd0;
            for (int k = NCH - 1; k >= 0; k--) if (hung[k]) m_chan = 5'(k);
        end else if (timeout) begin
            m_done = 1'b1; m_status = 3'd3;
        end
    endtask

    task automatic run_sched(input logic [31:0] maxc, input logic ff, input int abort_at);
        int post;
        post = 0;
        do_reset();
        maxcycles = maxc;
        fail_fast = ff;
        for (int c = 0; c < MAXC; c++) begin
            apply_inputs(c);
            model_step(c, maxc, ff);
            @(posedge clk); #1;
            check_eq("done", {31'd0, done}, {31'd0, m_done});
            check_eq("status", {29'd0, status}, {29'd0, m_status});
            check_eq("finished", {28'd0, finished}, {28'd0, m_fin});
            check_eq("fail_mask", {28'd0, fail_mask}, {28'd0, m_fmask});
            check_eq("tat", tat, m_tat);
            if (c == abort_at) begin
                #3; rst_n = 1'b0; #2;
                check_reset_vals();
                return;
            end
            if (m_done) post++;
            if (post > 4) break;
        end
        check_eq("fail_chan", {27'd0, fail_chan}, {27'd0, m_chan});
        check_eq("fail_value", fail_value, m_val);
        check_eq("run_bound", {31'd0, done}, 32'd1);
        check_eq("done_core_rst", {31'd0, core_rst_n}, 32'd1);
        clear_inputs();
    endtask

    task automatic sched_all_pass();
        clear_sched();
        for (int k = 0; k < NCH; k++) s_pass[10 * (k + 1)][k] = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; fail_fast = 1'b0; maxcycles = 32'd0;
        clear_inputs();

        // All channels pass at RUN cycles 10/20/30/40.
        sched_all_pass();
        run_sched(32'd0, 1'b0, -1);
        check_eq("pass_status", {29'd0, status}, 32'(ST_PASS));
        check_eq("pass_tat", tat, 32'd41);
        // Asynchronous reset while in DONE.
        #3; rst_n = 1'b0; #2;
        check_reset_vals();

        // Fail-fast with a same-cycle tie: exit code 7 on ch2, failed on ch1.
        clear_sched();
        s_exit[3][2] = 1'b1; s_code[3][2] = 32'd7; s_fail[3][1] = 1'b1;
        run_sched(32'd0, 1'b1, -1);
        check_eq("tie_status", {29'd0, status}, 32'(ST_FAIL));
        check_eq("tie_chan", {27'd0, fail_chan}, 32'd1);
        check_eq("tie_value", fail_value, 32'd0);
        check_eq("tie_mask", {28'd0, fail_mask}, 32'h6);

        // Timeout with no events, then all pass in the last allowed cycle.
        clear_sched();
        run_sched(32'd100, 1'b0, -1);
        check_eq("to_status", {29'd0, status}, 32'(ST_TIMEOUT));
        check_eq("to_tat", tat, 32'd100);
        clear_sched();
        s_pass[99] = 4'hF;
        run_sched(32'd100, 1'b0, -1);
        check_eq("to_pass_status", {29'd0, status}, 32'(ST_PASS));
        check_eq("to_pass_tat", tat, 32'd100);

        // Collect mode: early failing exit code waits for the last channel.
        clear_sched();
        s_pass[1] = 4'b1100;
        s_exit[5][0] = 1'b1; s_code[5][0] = 32'd3;
        s_pass[50][1] = 1'b1;
        run_sched(32'd0, 1'b0, -1);
        check_eq("col_status", {29'd0, status}, 32'(ST_FAIL));
        check_eq("col_tat", tat, 32'd51);
        check_eq("col_value", fail_value, 32'd3);
        check_eq("col_chan", {27'd0, fail_chan}, 32'd0);

        // Reset in the middle of RUN, then a clean rerun.
        sched_all_pass();
        run_sched(32'd0, 1'b0, 20);
        run_sched(32'd0, 1'b0, -1);
        check_eq("rerun_status", {29'd0, status}, 32'(ST_PASS));

        // No retirement at all: hang when the watchdog exists, timeout otherwise.
        clear_sched();
        for (int c = 0; c < MAXC; c++) s_ret[c] = '0;
`ifdef CV32E40P_TB_RUN_MONITOR_HANG_WATCHDOG_EN
        run_sched(32'd0, 1'b0, -1);
        check_eq("hang_status", {29'd0, status}, 32'(ST_HANG));
        check_eq("hang_tat", tat, 32'd16);
        check_eq("hang_chan", {27'd0, fail_chan}, 32'd0);
`else
        run_sched(32'd40, 1'b0, -1);
        check_eq("nohang_status", {29'd0, status}, 32'(ST_TIMEOUT));
        check_eq("nohang_tat", tat, 32'd40);
`endif

        // Randomized schedules.
        for (int r = 0; r < 12; r++) begin
            int rnd;
            clear_sched();
            for (int c = 0; c < MAXC; c++) begin
                for (int k = 0; k < NCH; k++) begin
                    rnd = int'($urandom_range(0, 199));
                    s_pass[c][k] = (rnd < 4) || (rnd == 10);
                    s_fail[c][k] = (rnd == 4) || (rnd == 5) || (rnd == 10);
                    s_exit[c][k] = (rnd >= 6) && (rnd < 10);
                    s_code[c][k] = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 255));
                    s_ret[c][k]  = ($urandom_range(0, 7) != 0);
                end
            end
            run_sched(32'($urandom_range(20, 250)), 1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
